// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by the fetch controller and its skid buffer.
package fetch_pkg;

  localparam int          FETCH_PC_W     = 10;
  localparam logic [9:0]  FETCH_RESET_PC = 10'h000;
  localparam logic [31:0] FETCH_NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer for a fetch that completes while stalled.
// Holds the instruction word and its PC+4.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int PC_W = FETCH_PC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            unload,
  input  logic            flush,
  input  logic [31:0]     load_instr,
  input  logic [PC_W-1:0] load_pc4,
  output logic            vld,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] pc4
);

  logic            vld_q, vld_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc4_q, pc4_d;

  always_comb begin
    vld_d   = vld_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (flush || unload) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d   = 1'b1;
      instr_d = load_instr;
      pc4_d   = load_pc4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign vld   = vld_q;
  assign instr = instr_q;
  assign pc4   = pc4_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem handshake,
// and applies stalls and branch/jump redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = FETCH_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(FETCH_RESET_PC),
  parameter logic [31:0]     NOP_WORD = FETCH_NOP
) (
  input  logic            CLOCK,
  input  logic            RESET_N,
  input  logic            Stall,
  input  logic            BranchTaken,
  input  logic [PC_W-1:0] PCBranch,
  input  logic            Jump,
  input  logic [PC_W-1:0] JumpTarget,
  output logic            IMemReq,
  output logic [PC_W-1:0] IMemAddr,
  input  logic            IMemReady,
  input  logic [31:0]     IMemData,
  output logic [PC_W-1:0] PCPlusFour,
  output logic [31:0]     Instruction,
  output logic            InstrValid
);

  fetch_state_e state_q, state_d;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc4_q, pc4_d;
  logic [31:0]     instr_q, instr_d;
  logic            vld_q, vld_d;
  logic            kill_q, kill_d;
  logic [PC_W-1:0] kaddr_q, kaddr_d;

  logic            redirect;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_plus4;

  logic            buf_load;
  logic            buf_unload;
  logic            buf_flush;
  logic            buf_vld;
  logic [31:0]     buf_instr;
  logic [PC_W-1:0] buf_pc4;

  assign redirect = BranchTaken | Jump;
  assign target   = (BranchTaken ? PCBranch : JumpTarget)
                  & ~PC_W'(3);
  assign pc_plus4 = pc_q + PC_W'(4);

  fetch_skid_buf #(
    .PC_W (PC_W)
  ) u_skid (
    .clk        (CLOCK),
    .rst_n      (RESET_N),
    .load       (buf_load),
    .unload     (buf_unload),
    .flush      (buf_flush),
    .load_instr (IMemData),
    .load_pc4   (pc_plus4),
    .vld        (buf_vld),
    .instr      (buf_instr),
    .pc4        (buf_pc4)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc4_d      = pc4_q;
    instr_d    = instr_q;
    vld_d      = vld_q;
    kill_d     = kill_q;
    kaddr_d    = kaddr_q;
    buf_load   = 1'b0;
    buf_unload = 1'b0;
    buf_flush  = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) pc_d = target;
      end
      FETCH: begin
        if (redirect) begin
          instr_d   = NOP_WORD;
          vld_d     = 1'b0;
          pc_d      = target;
          buf_flush = 1'b1;
          // an unfinished request must complete on its old address
          if (!IMemReady) begin
            kill_d = 1'b1;
            if (!kill_q) kaddr_d = pc_q;
          end else begin
            kill_d = 1'b0;
          end
        end else if (kill_q) begin
          if (IMemReady) kill_d = 1'b0;
          if (!Stall) begin
            instr_d = NOP_WORD;
            vld_d   = 1'b0;
          end
        end else if (IMemReady) begin
          if (Stall) begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end else begin
            instr_d = IMemData;
            pc4_d   = pc_plus4;
            vld_d   = 1'b1;
            pc_d    = pc_plus4;
          end
        end else if (!Stall) begin
          instr_d = NOP_WORD;
          vld_d   = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          instr_d   = NOP_WORD;
          vld_d     = 1'b0;
          pc_d      = target;
          buf_flush = 1'b1;
          state_d   = FETCH;
        end else if (!buf_vld) begin
          state_d = FETCH;
        end else if (!Stall) begin
          instr_d    = buf_instr;
          pc4_d      = buf_pc4;
          vld_d      = 1'b1;
          pc_d       = buf_pc4;
          buf_unload = 1'b1;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pc4_q   <= '0;
      instr_q <= NOP_WORD;
      vld_q   <= 1'b0;
      kill_q  <= 1'b0;
      kaddr_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      kill_q  <= kill_d;
      kaddr_q <= kaddr_d;
    end
  end

  assign IMemReq     = (state_q == FETCH);
  assign IMemAddr    = kill_q ? kaddr_q : pc_q;
  assign PCPlusFour  = pc4_q;
  assign Instruction = instr_q;
  assign InstrValid  = vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transaction-level reference model.
// Memory returns 0xC0DE0000 | address for every fetch.
module tb_fetch_unit;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [9:0]  PCBranch = '0;
  logic        Jump = 1'b0;
  logic [9:0]  JumpTarget = '0;
  logic        IMemReq;
  logic [9:0]  IMemAddr;
  logic        IMemReady = 1'b0;
  logic [31:0] IMemData;
  logic [9:0]  PCPlusFour;
  logic [31:0] Instruction;
  logic        InstrValid;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  fetch_unit dut (
    .CLOCK       (CLOCK),
    .RESET_N     (RESET_N),
    .Stall       (Stall),
    .BranchTaken (BranchTaken),
    .PCBranch    (PCBranch),
    .Jump        (Jump),
    .JumpTarget  (JumpTarget),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemReady   (IMemReady),
    .IMemData    (IMemData),
    .PCPlusFour  (PCPlusFour),
    .Instruction (Instruction),
    .InstrValid  (InstrValid)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic logic [31:0] word(input logic [9:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  assign IMemData = word(IMemAddr);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: next PC, a stale address whose reply is dropped,
  // and at most one completed-but-held fetch.
  bit          m_on = 0;
  logic [9:0]  m_pc = '0;
  bit          m_stale = 0;
  logic [9:0]  m_stale_a = '0;
  bit          m_held_v = 0;
  logic [9:0]  m_held_a = '0;
  logic [31:0] m_instr = '0;
  logic [9:0]  m_pc4 = '0;
  bit          m_valid = 0;

  function automatic bit m_req();
    return m_on && !m_held_v;
  endfunction

  function automatic logic [9:0] m_addr();
    return m_stale ? m_stale_a : m_pc;
  endfunction

  task automatic model_reset();
    m_on = 0; m_pc = '0; m_stale = 0; m_held_v = 0;
    m_instr = '0; m_pc4 = '0; m_valid = 0;
  endtask

  task automatic bubble();
    if (!Stall) begin
      m_instr = '0;
      m_valid = 0;
    end
  endtask

  task automatic model_step();
    logic [9:0] tgt, a;
    bit redir, req, done;
    redir = BranchTaken || Jump;
    tgt   = (BranchTaken ? PCBranch : JumpTarget) & 10'h3FC;
    req   = m_req();
    a     = m_addr();
    done  = req && IMemReady;
    if (!m_on) begin
      m_on = 1;
      if (redir) m_pc = tgt;
    end else if (redir) begin
      m_instr = '0; m_valid = 0; m_held_v = 0; m_pc = tgt;
      if (req && !IMemReady) begin
        if (!m_stale) m_stale_a = a;
        m_stale = 1;
      end else begin
        m_stale = 0;
      end
    end else if (m_held_v) begin
      if (!Stall) begin
        m_instr = word(m_held_a); m_pc4 = m_held_a + 10'd4;
        m_valid = 1; m_pc = m_held_a + 10'd4; m_held_v = 0;
      end
    end else if (done && m_stale) begin
      m_stale = 0;
      bubble();
    end else if (done) begin
      if (!Stall) begin
        m_instr = word(a); m_pc4 = a + 10'd4;
        m_valid = 1; m_pc = a + 10'd4;
      end else begin
        m_held_v = 1; m_held_a = a;
      end
    end else begin
      bubble();
    end
  endtask

  always @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) model_reset();
    else model_step();
  end

  always @(negedge CLOCK) begin
    if (cmp_en) begin
      chk("req", {31'd0, IMemReq}, {31'd0, m_req()});
      if (m_req()) chk("addr", {22'd0, IMemAddr}, {22'd0, m_addr()});
      chk("valid", {31'd0, InstrValid}, {31'd0, m_valid});
      chk("instr", Instruction, m_instr);
      chk("pc4", {22'd0, PCPlusFour}, {22'd0, m_pc4});
    end
  end

  task automatic cyc(input logic st, input logic br,
                     input logic [9:0] pb, input logic jp,
                     input logic [9:0] jt, input logic rdy);
    Stall = st; BranchTaken = br; PCBranch = pb;
    Jump = jp; JumpTarget = jt; IMemReady = rdy;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic lit(input string nm, input logic [31:0] ins,
                     input logic [9:0] p4, input logic v);
    chk({nm, "_instr"}, Instruction, ins);
    chk({nm, "_pc4"}, {22'd0, PCPlusFour}, {22'd0, p4});
    chk({nm, "_valid"}, {31'd0, InstrValid}, {31'd0, v});
  endtask

  task automatic lreq(input string nm, input logic r,
                      input logic [9:0] a);
    chk({nm, "_req"}, {31'd0, IMemReq}, {31'd0, r});
    if (r) chk({nm, "_addr"}, {22'd0, IMemAddr}, {22'd0, a});
  endtask

  initial begin
    cmp_en = 1'b1;
    repeat (2) @(posedge CLOCK);
    #1;
    lit("rst", 32'h0, 10'h000, 1'b0);
    lreq("rst", 1'b0, 10'h000);
    RESET_N = 1'b1;

    cyc(0, 0, 0, 0, 0, 1);
    lit("t1_e1", 32'h0, 10'h000, 1'b0);
    lreq("t1_e1", 1'b1, 10'h000);
    cyc(0, 0, 0, 0, 0, 1);
    lit("t1_w0", 32'hC0DE_0000, 10'h004, 1'b1);
    cyc(0, 0, 0, 0, 0, 1);
    lit("t1_w4", 32'hC0DE_0004, 10'h008, 1'b1);
    cyc(0, 0, 0, 0, 0, 1);
    lit("t1_w8", 32'hC0DE_0008, 10'h00C, 1'b1);

    cyc(0, 0, 0, 0, 0, 1);
    lreq("t2_start", 1'b1, 10'h010);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      lreq("t2_wait", 1'b1, 10'h010);
      chk("t2_wait_valid", {31'd0, InstrValid}, 32'd0);
    end
    cyc(0, 0, 0, 0, 0, 1);
    lit("t2_w10", 32'hC0DE_0010, 10'h014, 1'b1);

    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    lreq("t3_pre", 1'b1, 10'h020);
    cyc(1, 0, 0, 0, 0, 1);
    lit("t3_hold1", 32'hC0DE_001C, 10'h020, 1'b1);
    lreq("t3_hold1", 1'b0, 10'h000);
    cyc(1, 0, 0, 0, 0, 0);
    lit("t3_hold2", 32'hC0DE_001C, 10'h020, 1'b1);
    lreq("t3_hold2", 1'b0, 10'h000);
    cyc(0, 0, 0, 0, 0, 1);
    lit("t3_rel", 32'hC0DE_0020, 10'h024, 1'b1);
    lreq("t3_rel", 1'b1, 10'h024);

    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    lreq("t4_pre", 1'b1, 10'h030);
    cyc(0, 1, 10'h100, 0, 0, 0);
    lit("t4_br", 32'h0, 10'h030, 1'b0);
    lreq("t4_br", 1'b1, 10'h030);
    cyc(0, 0, 0, 0, 0, 0);
    lreq("t4_wait", 1'b1, 10'h030);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t4_drop_valid", {31'd0, InstrValid}, 32'd0);
    lreq("t4_tgt", 1'b1, 10'h100);
    cyc(0, 0, 0, 0, 0, 1);
    lit("t4_w100", 32'hC0DE_0100, 10'h104, 1'b1);

    cyc(1, 1, 10'h200, 1, 10'h300, 1);
    lit("t5_flush", 32'h0, 10'h104, 1'b0);
    lreq("t5_flush", 1'b1, 10'h200);
    cyc(0, 0, 0, 0, 0, 1);
    lit("t5_w200", 32'hC0DE_0200, 10'h204, 1'b1);

    cyc(0, 0, 0, 1, 10'h050, 0);
    lreq("t6_j1", 1'b1, 10'h204);
    cyc(0, 0, 0, 1, 10'h3FE, 0);
    lreq("t6_j2", 1'b1, 10'h204);
    cyc(0, 0, 0, 0, 0, 1);
    lreq("t6_tgt", 1'b1, 10'h3FC);
    cyc(0, 0, 0, 0, 0, 1);
    lit("t6_wrap", 32'hC0DE_03FC, 10'h000, 1'b1);
    lreq("t6_wrap", 1'b1, 10'h000);

    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    lreq("t7_hold", 1'b0, 10'h000);
    cyc(1, 1, 10'h080, 0, 0, 0);
    lit("t7_flush", 32'h0, 10'h004, 1'b0);
    lreq("t7_flush", 1'b1, 10'h080);
    cyc(0, 0, 0, 0, 0, 1);
    lit("t7_w80", 32'hC0DE_0080, 10'h084, 1'b1);

    cyc(0, 0, 0, 0, 0, 0);
    lreq("t8_wait", 1'b1, 10'h084);
    #2;
    RESET_N = 1'b0;
    #1;
    lit("t8_rst", 32'h0, 10'h000, 1'b0);
    lreq("t8_rst", 1'b0, 10'h000);
    @(posedge CLOCK);
    #1;
    RESET_N = 1'b1;
    cyc(0, 0, 0, 0, 0, 1);
    lreq("t8_e1", 1'b1, 10'h000);
    cyc(0, 0, 0, 0, 0, 1);
    lit("t8_w0", 32'hC0DE_0000, 10'h004, 1'b1);

    repeat (2) @(negedge CLOCK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register; produces the PCPlusFour and Instruction values that register latches.
- Owns the program counter and drives a request/ready instruction-memory interface that tolerates wait states.
- Applies stalls from the hazard logic and redirects from the branch outcome (MEM stage) and jump (ID stage).
- Holds one instruction in a skid buffer when a fetch completes during a stall.

Parameters:
PC_W, 10, program-counter width in bits (byte address, word aligned)
RESET_PC, 10'h000, PC value loaded on reset
NOP_WORD, 32'h00000000, instruction word driven when no valid instruction is present

Ports:
CLOCK  input  1  system clock; all state updates on the rising edge
RESET_N  input  1  asynchronous, active-low reset
Stall  input  1  hold the fetch outputs and PC (from the hazard unit)
BranchTaken  input  1  redirect to PCBranch (from the MEM stage; BranchOut and the zero flag)
PCBranch  input  PC_W  branch target
Jump  input  1  redirect to JumpTarget (from the ID stage)
JumpTarget  input  PC_W  jump target
IMemReq  output  1  instruction-memory request
IMemAddr  output  PC_W  fetch address
IMemReady  input  1  memory returns IMemData this cycle
IMemData  input  32  instruction word
PCPlusFour  output  PC_W  PC+4 of the instruction on Instruction
Instruction  output  32  fetched instruction, registered
InstrValid  output  1  Instruction holds a real instruction

Behaviour:
- Clock and reset: one clock, CLOCK. RESET_N is asynchronous and active-low.
- Reset values: PC=RESET_PC, Instruction=NOP_WORD, PCPlusFour=0, InstrValid=0, IMemReq=0, kill=0, buffer empty, state IDLE.
- A reset asserted mid-fetch abandons the outstanding request. The memory side is also reset.
- States:
  - IDLE: a single cycle after reset release, then go to FETCH.
  - FETCH: IMemReq=1, IMemAddr=PC.
  - HOLD: IMemReq=0; the buffer holds a completed fetch.
- Handshake: once IMemReq is raised, it and IMemAddr stay stable until a cycle with IMemReady=1. Same-cycle ready is legal, so zero-wait memory sustains one fetch per cycle.
- FETCH with IMemReady=1, no kill, Stall=0:
  - Instruction<=IMemData, PCPlusFour<=PC+4, InstrValid<=1, PC<=PC+4.
  - Stay in FETCH.
- FETCH with IMemReady=1, no kill, Stall=1:
  - Write buffer<=IMemData and bufPC4<=PC+4.
  - Go to HOLD. Outputs are unchanged.
- FETCH with IMemReady=0 and Stall=1: keep waiting, with the request held.
- HOLD with Stall=0:
  - Instruction<=buffer, PCPlusFour<=bufPC4, InstrValid<=1, PC<=bufPC4.
  - Go to FETCH.
- Stall=1 with no completion: Instruction, PCPlusFour, InstrValid and PC all hold.
- Redirect:
  - Priority order: BranchTaken, then Jump, then sequential.
  - A redirect overrides Stall.
  - In the redirect cycle: Instruction<=NOP_WORD, InstrValid<=0, buffer discarded, PC<=target.
  - If a request is outstanding and IMemReady=0, set kill and stay in FETCH on the old address.
  - When the killed request's IMemReady arrives: discard the data, clear kill, and issue PC (the target) on the following cycle.
  - If IMemReady=1 in the redirect cycle itself, discard the data and do not set kill.
  - A second redirect while kill is set only updates PC; the latest target wins.
  - BranchTaken and Jump in the same cycle: the branch wins.
- Arithmetic: PC+4 is modulo 2^PC_W, so 10'h3FC+4 = 10'h000 with no error. Targets are taken as given; bits [1:0] are ignored and forced to 0 in the PC.
- Latency: zero-wait memory gives the first valid Instruction on the 2nd rising edge after RESET_N deasserts.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {IDLE, FETCH, HOLD}
  - NOP_WORD and RESET_PC constants
  - the PC_W default
- Pipeline and controller blocks import the same NOP and PC_W constants.
- One natural sub-module, fetch_skid_buf: a one-entry buffer with load, unload and flush, holding the instruction word and PC+4.

Test Plan:
- Reset release, IMemReady tied to 1, memory returns addr-tagged words: Instruction sequence is words @0,@4,@8, PCPlusFour is 4,8,12, and InstrValid rises on the 2nd edge.
- IMemReady low for 3 cycles on address 0x010: IMemReq and IMemAddr stay 0x010 for all 4 cycles, InstrValid is 0 for those cycles, then the word is captured with PCPlusFour=0x014.
- Stall=1 in the same cycle a fetch of 0x020 completes, stall held 2 cycles: outputs frozen and IMemReq=0 in HOLD. On release, Instruction=word@0x020, PCPlusFour=0x024, and the next fetch is 0x024.
- BranchTaken=1, PCBranch=0x100, while the fetch of 0x030 waits 2 more cycles: InstrValid=0 and Instruction=0, the 0x030 data is discarded, and the next IMemAddr is 0x100.
- BranchTaken=1 to 0x200 and Jump=1 to 0x300 in the same cycle with Stall=1: PC becomes 0x200, flush occurs despite the stall, and the next fetch is 0x200.
- PC=0x3FC completes a fetch: PCPlusFour=0x000 and the next fetch address is 0x000. Async reset asserted mid-wait: IMemReq drops immediately and all outputs return to their reset values.
